// File: rtl/shift_sequencer.sv
// Multi-cycle N-position shift controller driving one shared single-step shifter.
// Optional SHIFT_EARLY_EXIT_EN ends the SHIFT phase once work_reg can no longer change.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [1:0]       req_op,
    input  logic [CNT_W-1:0] req_amt,
    output logic [WIDTH-1:0] sh_in,
    output logic [1:0]       sh_shift,
    input  logic [WIDTH-1:0] sh_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] work_reg;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_reg;
    logic             accept;
    logic             settled;

    assign accept = req_valid && (state == IDLE);

`ifdef SHIFT_EARLY_EXIT_EN
    // Fixed points of the shifter: further steps leave work_reg unchanged.
    always_comb begin
        settled = 1'b0;
        if (op_reg == 2'b11)
            settled = (work_reg == '0) || (work_reg == '1);
        else
            settled = (work_reg == '0);
    end
`else
    assign settled = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_valid)
                    state_nxt = (req_amt == '0 || req_op == 2'b00)
                              ? DONE : SHIFT;
            end
            SHIFT: begin
                if (settled || cnt == CNT_W'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_reg <= '0;
            cnt      <= '0;
            op_reg   <= 2'b00;
        end else if (accept) begin
            work_reg <= req_data;
            cnt      <= req_amt;
            op_reg   <= req_op;
        end else if (state == SHIFT && !settled) begin
            work_reg <= sh_out;
            cnt      <= cnt - CNT_W'(1);
        end
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        sh_shift  = 2'b00;
        unique case (state)
            IDLE:  req_ready = 1'b1;
            SHIFT: begin
                busy     = 1'b1;
                sh_shift = op_reg;
            end
            DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
            end
            default: req_ready = 1'b0;
        endcase
    end

    assign sh_in    = work_reg;
    assign rsp_data = work_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural single-step shifter.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_data = '0;
    logic [1:0]  req_op = 2'b00;
    logic [3:0]  req_amt = '0;
    logic [15:0] sh_in;
    logic [1:0]  sh_shift;
    logic [15:0] sh_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_op    (req_op),
        .req_amt   (req_amt),
        .sh_in     (sh_in),
        .sh_shift  (sh_shift),
        .sh_out    (sh_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        sh_out = sh_in;
        case (sh_shift)
            2'b01:   sh_out = {sh_in[14:0], 1'b0};
            2'b10:   sh_out = {1'b0, sh_in[15:1]};
            2'b11:   sh_out = {sh_in[15], sh_in[15:1]};
            default: sh_out = sh_in;
        endcase
    end

    typedef struct {
        logic [15:0] data;
        logic [1:0]  op;
        logic [3:0]  amt;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input string name, input logic [15:0] d,
                          input logic [1:0] op, input logic [3:0] amt,
                          input logic [15:0] exp, input int lat,
                          input int hold);
        int  n;
        bit  got;
        bit  shz;
        @(negedge clk);
        chk({name, " ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_data  = d;
        req_op    = op;
        req_amt   = amt;
        n   = 0;
        got = 1'b0;
        shz = 1'b1;
        while (n < 40 && !got) begin
            @(posedge clk);
            #1;
            n++;
            req_valid = 1'b0;
            if (sh_shift != 2'b00) shz = 1'b0;
            if (rsp_valid) got = 1'b1;
        end
        chk({name, " rsp_seen"}, {31'd0, got}, 32'd1);
        chk({name, " latency"}, n, lat);
        chk({name, " data"}, {16'd0, rsp_data}, {16'd0, exp});
        if (op == 2'b00 || amt == 4'd0)
            chk({name, " sh_shift_idle"}, {31'd0, shz}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_data  = 16'hDEAD;
            req_op    = 2'b01;
            req_amt   = 4'd1;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            chk({name, " hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({name, " hold_data"}, {16'd0, rsp_data}, {16'd0, exp});
            chk({name, " hold_ready"}, {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({name, " drained"}, {30'd0, rsp_valid, busy}, 32'd0);
        chk({name, " idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({name, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({name, " busy"}, {31'd0, busy}, 32'd0);
        chk({name, " rsp_data"}, {16'd0, rsp_data}, 32'd0);
        chk({name, " sh_in"}, {16'd0, sh_in}, 32'd0);
        chk({name, " sh_shift"}, {30'd0, sh_shift}, 32'd0);
    endtask

    vec_t vecs[11];

    initial begin
        int  ea;
        int  eb;
        bit  spurious;
`ifdef SHIFT_EARLY_EXIT_EN
        ea = 2;
        eb = 7;
`else
        ea = 13;
        eb = 10;
`endif
        vecs[0]  = '{16'h0001, 2'b01, 4'd3,  16'h0008, 4};
        vecs[1]  = '{16'h8000, 2'b11, 4'd15, 16'hFFFF, 16};
        vecs[2]  = '{16'h8000, 2'b10, 4'd15, 16'h0001, 16};
        vecs[3]  = '{16'h1234, 2'b01, 4'd0,  16'h1234, 1};
        vecs[4]  = '{16'h1234, 2'b00, 4'd7,  16'h1234, 1};
        vecs[5]  = '{16'hA5A5, 2'b10, 4'd4,  16'h0A5A, 5};
        vecs[6]  = '{16'h8421, 2'b11, 4'd1,  16'hC210, 2};
        vecs[7]  = '{16'h7FFF, 2'b11, 4'd3,  16'h0FFF, 4};
        vecs[8]  = '{16'hFFFF, 2'b11, 4'd12, 16'hFFFF, ea};
        vecs[9]  = '{16'h0010, 2'b10, 4'd9,  16'h0000, eb};
        vecs[10] = '{16'h00F0, 2'b01, 4'd8,  16'hF000, 9};

        #2;
        chk_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            do_req($sformatf("vec%0d", i), vecs[i].data, vecs[i].op,
                   vecs[i].amt, vecs[i].exp, vecs[i].lat, 0);

        do_req("backpressure", 16'h0001, 2'b01, 4'd3, 16'h0008, 4, 5);
        do_req("after_bp", 16'h0F00, 2'b10, 4'd4, 16'h00F0, 5, 0);

        @(negedge clk);
        req_valid = 1'b1;
        req_data  = 16'h00F0;
        req_op    = 2'b01;
        req_amt   = 4'd8;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort shift1", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #2;
        chk("abort shift2 sh_in", {16'd0, sh_in}, 32'h000001E0);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) spurious = 1'b1;
        end
        chk("abort no_rsp", {31'd0, spurious}, 32'd0);
        do_req("after_abort", 16'h0003, 2'b01, 4'd2, 16'h000C, 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
